// File: rtl/pool_window_sequencer_pkg.sv
// Shared types and helpers for the 2x2/stride-2 pooling window sequencer.
package pool_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    PAIR  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // In-window winner positions, reported on out_index
  localparam logic [1:0] POS_TL = 2'd0;
  localparam logic [1:0] POS_TR = 2'd1;
  localparam logic [1:0] POS_BL = 2'd2;
  localparam logic [1:0] POS_BR = 2'd3;

  function automatic int unsigned col_w(input int unsigned img_w);
    return $clog2(img_w);
  endfunction

endpackage

// File: rtl/pool_window_sequencer_if.sv
// Pixel-in / pooled-out stream bundle; the sequencer sits on the slave side.
interface pool_window_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 13
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_index;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_index, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_index, out_last, out_valid
  );
endinterface

// File: rtl/pool_window_sequencer_comparator.sv
// Combinational N-way signed max/min select; element 0 sits in the MSBs and ties keep the lowest index.
module pool_window_sequencer_comparator #(
  parameter  int unsigned N          = 4,
  parameter  int unsigned DATA_WIDTH = 13,
  localparam int unsigned IW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*DATA_WIDTH-1:0] data_in,
  input  logic                    s,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [IW-1:0]           index
);

  logic signed [DATA_WIDTH-1:0] best_v;
  logic signed [DATA_WIDTH-1:0] cand;
  logic [IW-1:0]                best_i;

  // Strict compare so an equal later element never displaces an earlier one
  always_comb begin
    best_v = data_in[(N-1)*DATA_WIDTH +: DATA_WIDTH];
    best_i = '0;
    cand   = '0;
    for (int i = 1; i < N; i++) begin
      cand = data_in[(N-1-i)*DATA_WIDTH +: DATA_WIDTH];
      if (s ? (cand > best_v) : (cand < best_v)) begin
        best_v = cand;
        best_i = IW'(i);
      end
    end
    result = best_v;
    index  = best_i;
  end

endmodule

// File: rtl/pool_window_sequencer.sv
// Streaming 2x2/stride-2 pooling controller: buffers one row, forms windows, emits value + winner position.
module pool_window_sequencer
  import pool_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 13,
  parameter int unsigned IMG_W      = 16,
  parameter int unsigned IMG_H      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_mode,
  pool_window_sequencer_if.slave  bus,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CW = col_w(IMG_W);
  localparam int unsigned RW = col_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t                state, state_nxt;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  mode;
  logic [DATA_WIDTH-1:0] linebuf [IMG_W];
  logic [DATA_WIDTH-1:0] hold;
  logic                  in_rdy;
  logic                  fire;
  logic                  win_load;

  logic [DATA_WIDTH-1:0] out_data_q;
  logic [1:0]            out_index_q;
  logic                  out_last_q;
  logic                  out_valid_q;

  logic [4*DATA_WIDTH-1:0] window;
  logic [DATA_WIDTH-1:0]   cmp_result;
  logic [1:0]              cmp_index;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational handshake terms
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_rdy = 1'b1;
        if (bus.in_valid && col == COL_LAST) state_nxt = PAIR;
      end
      PAIR: begin
        in_rdy = col[0] ? (!out_valid_q || bus.out_ready) : 1'b1;
        if (bus.in_valid && in_rdy && col == COL_LAST)
          state_nxt = (row == ROW_LAST) ? DRAIN : FILL;
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fire     = bus.in_valid && in_rdy;
  assign win_load = fire && (state == PAIR) && col[0];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      mode <= 1'b0;
    end else if (state == IDLE && start) begin
      col  <= '0;
      row  <= '0;
      mode <= s_mode;
    end else if (fire) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Row storage and the bottom-left hold register carry no reset
  always_ff @(posedge clk) begin
    if (fire && state == FILL) linebuf[col] <= bus.in_data;
    if (fire && state == PAIR && !col[0]) hold <= bus.in_data;
  end

  assign window = {linebuf[col & ~CW'(1)], linebuf[col], hold, bus.in_data};

  pool_window_sequencer_comparator #(
    .N          (4),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .data_in (window),
    .s       (mode),
    .result  (cmp_result),
    .index   (cmp_index)
  );

  // A new window may reload the output register in the same cycle it is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_index_q <= POS_TL;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (win_load) begin
      out_data_q  <= cmp_result;
      out_index_q <= cmp_index;
      out_last_q  <= (row == ROW_LAST) && (col == COL_LAST);
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;

endmodule
